// File: rtl/bank_burst_ctrl_pkg.sv
// Shared types and helpers for the bank burst sequencer.
//   state_t   : sequencer FSM state (IDLE, BURST)
//   wrap_addr : address of beat k of a burst that wraps inside its
//               aligned BL-word block (DDR column wrap)
package ddr_burst_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Upper bits of base are kept; the low log2(bl) bits count modulo bl,
  // so a burst never leaves its aligned block. bl must be a power of two.
  function automatic int unsigned wrap_addr(input int unsigned base,
                                            input int unsigned k,
                                            input int unsigned bl);
    return (base & ~(bl - 1)) | ((base + k) & (bl - 1));
  endfunction

endpackage

// File: rtl/bank_burst_ctrl_if.sv
// Bus bundle between the burst sequencer and its environment.
//   Command side : cmd_valid/cmd_ready/cmd_wr/cmd_addr, write beats on wdata
//   Read return  : rdata/rdata_valid, busy status
//   SRAM side    : sram_addr/sram_rd_o_wr/sram_wdata out, sram_rdata in
// Modports:
//   slave  - the sequencer (bank_burst_ctrl)
//   master - the environment (command FSM plus the bank SRAM)
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_valid seen while cmd_ready is 0 is ignored and
// not remembered; the source may drop or change it freely. rdata_valid has
// no back-pressure: the consumer must take every beat when it is presented.
interface bank_burst_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2048
);
  localparam int AW = $clog2(DEPTH);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_wr;
  logic [AW-1:0]    cmd_addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             rdata_valid;
  logic             busy;
  logic [AW-1:0]    sram_addr;
  logic             sram_rd_o_wr;
  logic [WIDTH-1:0] sram_wdata;
  logic [WIDTH-1:0] sram_rdata;

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, wdata, sram_rdata,
    output cmd_ready, rdata, rdata_valid, busy,
           sram_addr, sram_rd_o_wr, sram_wdata
  );

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, wdata, sram_rdata,
    input  cmd_ready, rdata, rdata_valid, busy,
           sram_addr, sram_rd_o_wr, sram_wdata
  );
endinterface

// File: rtl/bank_burst_ctrl_delay_line.sv
// Fixed-length register delay line.
//   clk, rst : clock, synchronous active-high reset (clears every stage)
//   i_d      : input word
//   o_q      : i_d delayed by STAGES cycles; STAGES=0 is a wire
module delay_line #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (STAGES == 0) begin : g_pass
      // Clock and reset are not needed for a pass-through.
      logic w_unused;
      assign w_unused = clk ^ rst;
      assign o_q      = i_d;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_pipe [STAGES];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < STAGES; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= i_d;
          for (int i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign o_q = r_pipe[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/bank_burst_ctrl.sv
// Column-burst sequencer for one emulated DRAM bank.
// Each accepted command (read or write, start column) becomes BL consecutive
// accesses on the bank SRAM, wrapping inside the aligned BL block. Read data
// returns on rdata/rdata_valid CL cycles after the matching SRAM access.
//   clk, rst    : clock, synchronous active-high reset
//   bus (slave) : command, read-return and SRAM signals (bank_burst_ctrl_if)
//   o_dbg_state : current FSM state
module bank_burst_ctrl
  import ddr_burst_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2048,
  parameter int BL    = 8,
  parameter int CL    = 3
) (
  input  logic               clk,
  input  logic               rst,
  bank_burst_ctrl_if.slave   bus,
  output state_t             o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int KW = $clog2(BL);
  localparam int FW = $clog2(CL + 1);

  state_t           r_state;
  logic [KW-1:0]    r_k;          // index of the beat now on the SRAM port
  logic             r_wr;
  logic [AW-1:0]    r_base;
  logic [AW-1:0]    r_addr;
  logic             r_rd_o_wr;
  logic [WIDTH-1:0] r_wdata;
  logic             r_cmd_ready;
  logic             r_beat_rd;    // a read beat is on the SRAM port this cycle
  logic [FW-1:0]    r_flight;     // cycles until the last read tag leaves the pipe

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_rdata;
  logic             w_rdata_valid;

  assign w_accept = bus.cmd_valid & r_cmd_ready;
  assign w_last   = (r_k == KW'(BL - 1));

  // Beat k is registered at the edge ending cycle T+k, so the SRAM sees it in
  // T+1+k and wdata beat k is sampled together with its address. cmd_ready is
  // registered one cycle ahead: it is 1 for the IDLE state and for the cycle
  // holding the last beat, which lets the next burst follow with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_wr        <= 1'b0;
      r_base      <= '0;
      r_addr      <= '0;
      r_rd_o_wr   <= 1'b0;
      r_wdata     <= '0;
      r_cmd_ready <= 1'b0;
      r_beat_rd   <= 1'b0;
      r_flight    <= '0;
    end else begin
      if (w_accept) begin
        r_state     <= BURST;
        r_k         <= '0;
        r_wr        <= bus.cmd_wr;
        r_base      <= bus.cmd_addr;
        r_addr      <= bus.cmd_addr;
        r_rd_o_wr   <= bus.cmd_wr;
        r_wdata     <= bus.wdata;
        r_beat_rd   <= ~bus.cmd_wr;
        r_cmd_ready <= 1'b0;
      end else if (r_state == BURST && !w_last) begin
        r_k         <= r_k + 1'b1;
        r_addr      <= AW'(wrap_addr(32'(r_base), 32'(r_k) + 32'd1, 32'(BL)));
        r_rd_o_wr   <= r_wr;
        r_wdata     <= bus.wdata;
        r_beat_rd   <= ~r_wr;
        r_cmd_ready <= (r_k == KW'(BL - 2));
      end else begin
        // Idle or burst finished without a follow-on: stop writing, keep the
        // address; the resulting idle SRAM reads are never tagged valid.
        r_state     <= IDLE;
        r_k         <= '0;
        r_rd_o_wr   <= 1'b0;
        r_beat_rd   <= 1'b0;
        r_cmd_ready <= 1'b1;
      end

      // Mirrors the valid delay line length so busy covers beats in flight.
      if (r_beat_rd)             r_flight <= FW'(CL);
      else if (r_flight != '0)   r_flight <= r_flight - 1'b1;
    end
  end

  // The SRAM adds one registered cycle, so data needs CL-1 more stages while
  // the tag, launched alongside the address, needs the full CL.
  delay_line #(.WIDTH(WIDTH), .STAGES(CL - 1)) u_rdata_dly (
    .clk (clk),
    .rst (rst),
    .i_d (bus.sram_rdata),
    .o_q (w_rdata)
  );

  delay_line #(.WIDTH(1), .STAGES(CL)) u_valid_dly (
    .clk (clk),
    .rst (rst),
    .i_d (r_beat_rd),
    .o_q (w_rdata_valid)
  );

  assign bus.cmd_ready    = r_cmd_ready;
  assign bus.sram_addr    = r_addr;
  assign bus.sram_rd_o_wr = r_rd_o_wr;
  assign bus.sram_wdata   = r_wdata;
  assign bus.rdata        = w_rdata;
  assign bus.rdata_valid  = w_rdata_valid;
  assign bus.busy         = (r_state == BURST) | (r_flight != '0);
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_bank_burst_ctrl.sv
module tb_bank_burst_ctrl;
  import ddr_burst_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2048;
  localparam int AW    = $clog2(DEPTH);
  localparam int BL    = 8;
  localparam int LB    = $clog2(BL);
  localparam int CL    = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- DUTs and SRAM models ----------------
  bank_burst_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();
  bank_burst_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus1 ();
  state_t dbg0, dbg1;

  logic          cmd_valid = 1'b0;
  logic          cmd_wr    = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [7:0]    wdata     = '0;

  assign bus0.cmd_valid = cmd_valid;
  assign bus0.cmd_wr    = cmd_wr;
  assign bus0.cmd_addr  = cmd_addr;
  assign bus0.wdata     = wdata;
  assign bus1.cmd_valid = cmd_valid;
  assign bus1.cmd_wr    = cmd_wr;
  assign bus1.cmd_addr  = cmd_addr;
  assign bus1.wdata     = wdata;

  logic [7:0] mem0 [DEPTH] = '{default: 8'h00};
  logic [7:0] mem1 [DEPTH] = '{default: 8'h00};
  logic [7:0] sram_q0 = 8'h00;
  logic [7:0] sram_q1 = 8'h00;

  always @(posedge clk) begin
    if (bus0.sram_rd_o_wr) mem0[bus0.sram_addr] <= bus0.sram_wdata;
    sram_q0 <= mem0[bus0.sram_addr];
    if (bus1.sram_rd_o_wr) mem1[bus1.sram_addr] <= bus1.sram_wdata;
    sram_q1 <= mem1[bus1.sram_addr];
  end
  assign bus0.sram_rdata = sram_q0;
  assign bus1.sram_rdata = sram_q1;

  bank_burst_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BL(BL), .CL(CL)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .o_dbg_state(dbg0)
  );

  bank_burst_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BL(BL), .CL(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .o_dbg_state(dbg1)
  );

  // ---------------- scoreboard ----------------
  logic [19:0] beat_q [$];   // {wr, addr, wdata}
  int          beat_t_q [$];
  logic [7:0]  rd_q [$];
  int          rd_t_q [$];
  logic [7:0]  rd1_q [$];
  int          rd1_t_q [$];
  logic [7:0]  ref_mem [DEPTH] = '{default: 8'h00};
  logic [7:0]  beat_d [BL];
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [AW-1:0] tb_wrap(input logic [AW-1:0] base, input int k);
    logic [AW-1:0] lo;
    lo = base + AW'(k);
    return {base[AW-1:LB], lo[LB-1:0]};
  endfunction

  task automatic push_exp(input logic wr, input logic [AW-1:0] base, input int t);
    logic [AW-1:0] a;
    for (int k = 0; k < BL; k++) begin
      a = tb_wrap(base, k);
      beat_q.push_back({wr, a, wr ? beat_d[k] : 8'h00});
      beat_t_q.push_back(t + 1 + k);
      if (wr) ref_mem[a] = beat_d[k];
      else begin
        rd_q.push_back(ref_mem[a]);
        rd_t_q.push_back(t + 1 + CL + k);
        rd1_q.push_back(ref_mem[a]);
        rd1_t_q.push_back(t + 2 + k);
      end
    end
  endtask

  // SRAM-port beats of the CL=3 instance, checked while it is in BURST.
  always @(negedge clk) begin : mon_beat
    logic [19:0] e;
    int          et;
    if (dbg0 == BURST) begin
      if (beat_q.size() == 0) chk("beat_unexpected", 1, 0);
      else begin
        e  = beat_q.pop_front();
        et = beat_t_q.pop_front();
        chk("beat_cycle", cyc, et);
        chk("beat_wr", bus0.sram_rd_o_wr, e[19]);
        chk("beat_addr", bus0.sram_addr, e[18:8]);
        if (e[19]) chk("beat_wdata", bus0.sram_wdata, e[7:0]);
      end
    end else if (bus0.sram_rd_o_wr) begin
      chk("stray_write", 1, 0);
    end
  end

  always @(negedge clk) begin : mon_rd0
    if (bus0.rdata_valid) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        chk("rd_data", bus0.rdata, rd_q.pop_front());
        chk("rd_cycle", cyc, rd_t_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin : mon_rd1
    if (bus1.rdata_valid) begin
      if (rd1_q.size() == 0) chk("cl1_rd_unexpected", 1, 0);
      else begin
        chk("cl1_rd_data", bus1.rdata, rd1_q.pop_front());
        chk("cl1_rd_cycle", cyc, rd1_t_q.pop_front());
        chk("cl1_raw_sram", bus1.rdata, bus1.sram_rdata);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    while (!bus0.cmd_ready && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_timeout", bus0.cmd_ready, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Returns in the last-beat cycle (T+BL) so a follow-on command is gapless.
  task automatic issue(input logic wr, input logic [AW-1:0] base, input logic [7:0] d0,
                       input logic rnd, output int t);
    for (int k = 0; k < BL; k++)
      beat_d[k] = rnd ? 8'($urandom_range(0, 255)) : d0 + 8'(k);
    wait_ready();
    t         = cyc;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = base;
    wdata     = beat_d[0];
    push_exp(wr, base, t);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("busy_start", bus0.busy, 1);
    for (int k = 1; k < BL; k++) begin
      wdata = beat_d[k];
      @(posedge clk); #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int t, last, n_acc;

    idle(3);
    chk("rst_cmd_ready", bus0.cmd_ready, 0);
    chk("rst_rdata_valid", bus0.rdata_valid, 0);
    chk("rst_rdata", bus0.rdata, 0);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_sram_rd_o_wr", bus0.sram_rd_o_wr, 0);
    chk("rst_sram_addr", bus0.sram_addr, 0);
    chk("rst_sram_wdata", bus0.sram_wdata, 0);
    rst = 1'b0;
    idle(1);
    chk("ready_after_rst", bus0.cmd_ready, 1);

    // Write then read 0x010
    issue(1'b1, 11'h010, 8'hA0, 1'b0, t);
    chk("wr_busy_last", bus0.busy, 1);
    idle(1);
    chk("wr_busy_end", bus0.busy, 0);
    issue(1'b0, 11'h010, 8'h00, 1'b0, t);
    idle(CL);
    chk("rd_busy_last_valid", bus0.busy, 1);
    idle(1);
    chk("rd_busy_end", bus0.busy, 0);

    // Back-to-back: write block 0x018, wrapped read 0x01D, then two more
    issue(1'b1, 11'h018, 8'hB0, 1'b0, t);
    issue(1'b0, 11'h01D, 8'h00, 1'b0, t);
    issue(1'b0, 11'h010, 8'h00, 1'b0, t);
    issue(1'b1, 11'h200, 8'h00, 1'b1, t);
    issue(1'b0, 11'h205, 8'h00, 1'b0, t);
    idle(15);

    // cmd_valid held high: one accept per BL cycles
    cmd_wr    = 1'b0;
    cmd_addr  = 11'h018;
    cmd_valid = 1'b1;
    wait_ready();
    last  = 0;
    n_acc = 0;
    for (int c = 0; c < 4 * BL; c++) begin
      if (bus0.cmd_ready) begin
        if (n_acc > 0) chk("held_interval", cyc - last, BL);
        last = cyc;
        n_acc++;
        push_exp(1'b0, 11'h018, cyc);
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("held_accepts", n_acc, 4);
    idle(12);

    // Random mix
    for (int i = 0; i < 6; i++) begin
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), 8'h00, 1'b1, t);
      idle($urandom_range(0, 3));
    end
    idle(20);
    chk("drain_beats", beat_q.size(), 0);
    chk("drain_reads", rd_q.size(), 0);
    chk("drain_cl1_reads", rd1_q.size(), 0);

    // Reset during beat 3 of a write over a pre-filled block
    issue(1'b1, 11'h100, 8'hE0, 1'b0, t);
    idle(2);
    for (int k = 0; k < BL; k++) beat_d[k] = 8'h50 + 8'(k);
    wait_ready();
    t         = cyc;
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = 11'h100;
    wdata     = beat_d[0];
    for (int k = 0; k < 3; k++) begin
      beat_q.push_back({1'b1, 11'h100 + 11'(k), beat_d[k]});
      beat_t_q.push_back(t + 1 + k);
      ref_mem[11'h100 + 11'(k)] = beat_d[k];
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wdata     = beat_d[1];
    @(posedge clk); #1;
    wdata     = beat_d[2];
    @(posedge clk); #1;
    wdata     = beat_d[3];
    rst       = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", bus0.busy, 0);
    chk("mid_rst_rdata_valid", bus0.rdata_valid, 0);
    chk("mid_rst_cmd_ready", bus0.cmd_ready, 0);
    chk("mid_rst_rd_o_wr", bus0.sram_rd_o_wr, 0);
    rst = 1'b0;
    idle(12);
    for (int k = 0; k < BL; k++)
      chk("mid_rst_mem", mem0[11'h100 + 11'(k)], (k < 3) ? 8'h50 + 8'(k) : 8'hE0 + 8'(k));
    chk("mid_rst_ready_back", bus0.cmd_ready, 1);

    chk("end_beats", beat_q.size(), 0);
    chk("end_reads", rd_q.size(), 0);
    chk("end_cl1_reads", rd1_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
